instr_issuer: RTL and testbench

Instruction issuer for the systolic array: accepts block-level commands (load inputs, load weights, run MAC, move outputs) and expands each into a stream of 64-bit instruction words, one per clock, driven straight into the controller's `instruction` input. It is the encoding end of the controller's instruction interface. It sits between the host/DMA command path and the controller. The controller samples every clock with no handshake, so this block owns all pacing.

---
 rtl/instr_issuer_if.sv | 29 ++
 rtl/instr_issuer.sv | 153 +++++++++++++++
 tb/tb_instr_issuer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issuer_if.sv
// Command, load-data and instruction-word signals of the instruction issuer.
// The host/DMA side uses the master modport; the issuer uses the slave modport.
`timescale 1ns/1ps
interface instr_issuer_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [15:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wdata_valid;
    logic             wdata_ready;
    logic [15:0]      wdata;
    logic [63:0]      instruction;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata,
        input  cmd_ready, wdata_ready, instruction, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata,
        output cmd_ready, wdata_ready, instruction, busy, done, err
    );
endinterface

// File: rtl/instr_issuer.sv
// Expands block-level commands into one 64-bit controller instruction per clock.
// Define INSTR_NOP_PAD_EN to fill load stall cycles with NOP words instead of zero.
`timescale 1ns/1ps
module instr_issuer #(
    parameter int LEN_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_issuer_if.slave bus
);
    localparam logic [2:0] OP_LOAD_INP  = 3'd0;
    localparam logic [2:0] OP_LOAD_WT   = 3'd1;
    localparam logic [2:0] OP_RUN_MAC   = 3'd2;
    localparam logic [2:0] OP_SEND_WT   = 3'd3;
    localparam logic [2:0] OP_STORE_OUT = 3'd4;
    localparam logic [2:0] OP_XMIT_OUT  = 3'd5;
    localparam logic [2:0] OP_WAIT      = 3'd6;
    localparam logic [2:0] OP_RSVD      = 3'd7;

    localparam logic [63:0]      NOP_WORD = 64'hF800_0000_0000_0000;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

`ifdef INSTR_NOP_PAD_EN
    localparam logic [63:0] STALL_WORD = NOP_WORD;
`else
    localparam logic [63:0] STALL_WORD = 64'h0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [15:0]      base_q, base_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [63:0]      instr_q, instr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             isLoad;
    logic             wordFire;
    logic             lastWord;
    logic [15:0]      wordAddr;

    function automatic logic [4:0] opcodeOf(input logic [2:0] op);
        logic [4:0] opc;
        case (op)
            OP_LOAD_INP:  opc = 5'b00100;
            OP_LOAD_WT:   opc = 5'b00101;
            OP_RUN_MAC:   opc = 5'b00001;
            OP_SEND_WT:   opc = 5'b00010;
            OP_STORE_OUT: opc = 5'b00011;
            OP_XMIT_OUT:  opc = 5'b00110;
            default:      opc = 5'b11111;
        endcase
        return opc;
    endfunction

    // A word is consumed every ISSUE cycle, except load cycles without data.
    assign isLoad   = (op_q == OP_LOAD_INP) || (op_q == OP_LOAD_WT);
    assign wordFire = (state_q == ISSUE) && (!isLoad || bus.wdata_valid);
    assign lastWord = wordFire && (count_q == len_q - LEN_ONE);
    assign wordAddr = base_q + 16'(count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            base_q  <= 16'h0;
            len_q   <= '0;
            count_q <= '0;
            instr_q <= 64'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            len_q   <= len_d;
            count_q <= count_d;
            instr_q <= instr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Zero-length and reserved commands skip ISSUE entirely.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        base_d  = base_q;
        len_d   = len_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    base_d  = bus.cmd_addr;
                    len_d   = bus.cmd_len;
                    count_d = '0;
                    if ((bus.cmd_len == '0) || (bus.cmd_op == OP_RSVD)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (wordFire) begin
                    count_d = count_q + LEN_ONE;
                end
                if (lastWord) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered, so each word appears one cycle after its ISSUE cycle.
    always_comb begin
        instr_d = 64'h0;
        done_d  = (state_q == DONE);
        err_d   = (state_q == DONE) && (op_q == OP_RSVD);
        if (state_q == ISSUE) begin
            if (op_q == OP_WAIT) begin
                instr_d = NOP_WORD;
            end else if (isLoad && !bus.wdata_valid) begin
                instr_d = STALL_WORD;
            end else begin
                instr_d = {opcodeOf(op_q), wordAddr,
                           (isLoad ? bus.wdata : 16'h0), 27'd0};
            end
        end
    end

    assign bus.instruction = instr_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.wdata_ready = (state_q == ISSUE) && isLoad;

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed scenarios plus random commands
// against an expected per-cycle output queue built from the word-format rules.
`timescale 1ns/1ps
module tb_instr_issuer;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks        = 0;
    int errors        = 0;
    int cycleCnt      = 0;
    int acceptCycle   = 0;
    int lastDoneCycle = -1;
    int lastErrCycle  = -1;

    localparam logic [63:0] NOP_WORD = 64'hF800_0000_0000_0000;
`ifdef INSTR_NOP_PAD_EN
    localparam logic [63:0] STALL_WORD = NOP_WORD;
    localparam int          STALLS_LOGGED = 2;
`else
    localparam logic [63:0] STALL_WORD = 64'h0;
    localparam int          STALLS_LOGGED = 0;
`endif

    typedef struct packed {
        logic [63:0] instr;
        logic        done;
        logic        err;
        logic        busy;
        logic        ready;
        logic        wready;
    } exp_t;

    exp_t        expQ[$];
    logic [63:0] seenWords[$];
    logic [15:0] dirData[4];
    bit          useDir = 1'b0;

    instr_issuer_if #(.LEN_W(8)) bus();

    instr_issuer #(.LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    function automatic exp_t mkExp(input logic [63:0] instr, input logic done, input logic err,
                                   input logic busy, input logic ready, input logic wready);
        exp_t e;
        e.instr  = instr;
        e.done   = done;
        e.err    = err;
        e.busy   = busy;
        e.ready  = ready;
        e.wready = wready;
        return e;
    endfunction

    function automatic logic [63:0] expWord(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] data);
        logic [4:0]  opc;
        logic [15:0] d;
        d = 16'h0;
        case (op)
            3'd0:    begin opc = 5'b00100; d = data; end
            3'd1:    begin opc = 5'b00101; d = data; end
            3'd2:    opc = 5'b00001;
            3'd3:    opc = 5'b00010;
            3'd4:    opc = 5'b00011;
            3'd5:    opc = 5'b00110;
            default: return NOP_WORD;
        endcase
        return {opc, addr, d, 27'd0};
    endfunction

    // One compare per output per cycle; an empty queue means the block must look idle.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) e = expQ.pop_front();
        else                 e = mkExp(64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("instruction", bus.instruction, e.instr);
        checkOutput("done", 64'(bus.done), 64'(e.done));
        checkOutput("err", 64'(bus.err), 64'(e.err));
        checkOutput("busy", 64'(bus.busy), 64'(e.busy));
        checkOutput("cmd_ready", 64'(bus.cmd_ready), 64'(e.ready));
        checkOutput("wdata_ready", 64'(bus.wdata_ready), 64'(e.wready));
        if (bus.instruction != 64'h0) seenWords.push_back(bus.instruction);
        if (bus.done) lastDoneCycle = cycleCnt;
        if (bus.err)  lastErrCycle  = cycleCnt;
    end

    task automatic cmdNoise();
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 3'($urandom);
        bus.cmd_addr  = 16'($urandom);
        bus.cmd_len   = 8'($urandom);
    endtask

    // Call during an IDLE cycle; returns in the IDLE cycle that shows the done pulse.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] len,
                                 input bit useMask, input logic [7:0] validMask, input int stallPct);
        bit          isLoad;
        bit          v;
        int          count;
        int          cyc;
        logic [15:0] wd;
        logic [63:0] word;
        isLoad        = (op <= 3'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(posedge clk); #1;
        acceptCycle = cycleCnt;
        cmdNoise();
        expQ.push_back(mkExp(64'h0, 1'b0, 1'b0, 1'b1, 1'b0, isLoad && (len != 8'd0)));
        count = 0;
        cyc   = 0;
        if (op != 3'd7) begin
            while (count < int'(len)) begin
                if (!isLoad)      v = 1'b1;
                else if (useMask) v = validMask[cyc % 8];
                else              v = ($urandom_range(0, 99) >= stallPct) || (cyc > 100);
                wd = (isLoad && useDir && count < 4) ? dirData[count] : 16'($urandom);
                bus.wdata_valid = isLoad ? v : 1'($urandom_range(0, 1));
                bus.wdata       = wd;
                if (op == 3'd6)            word = NOP_WORD;
                else if (isLoad && !v)     word = STALL_WORD;
                else                       word = expWord(op, addr + 16'(count), wd);
                @(posedge clk); #1;
                cmdNoise();
                if (v) count++;
                cyc++;
                expQ.push_back(mkExp(word, 1'b0, 1'b0, 1'b1, 1'b0, isLoad && (count < int'(len))));
            end
        end
        bus.wdata_valid = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        expQ.push_back(mkExp(64'h0, 1'b1, (op == 3'd7), 1'b0, 1'b1, 1'b0));
    endtask

    int doneBefore;
    int loadWtWords;
    int nopWords;

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 3'd0;
        bus.cmd_addr    = 16'h0;
        bus.cmd_len     = 8'd0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = 16'h0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_instr", bus.instruction, 64'h0);
        checkOutput("reset_busy", 64'(bus.busy), 64'h0);
        checkOutput("reset_ready", 64'(bus.cmd_ready), 64'h1);
        checkOutput("reset_wready", 64'(bus.wdata_ready), 64'h0);
        checkOutput("reset_done", 64'(bus.done), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] LOAD_INP addr=0x0010 len=3");
        seenWords.delete();
        dirData[0] = 16'hAAAA; dirData[1] = 16'hBBBB; dirData[2] = 16'hCCCC; dirData[3] = 16'h0;
        useDir = 1'b1;
        applyStimulus(3'd0, 16'h0010, 8'd3, 1'b1, 8'hFF, 0);
        useDir = 1'b0;
        checkOutput("ldinp_count", 64'(seenWords.size()), 64'd3);
        checkOutput("ldinp_w0", seenWords[0], 64'h2000_8555_5000_0000);
        checkOutput("ldinp_w1", seenWords[1], 64'h2000_8DDD_D800_0000);
        checkOutput("ldinp_w2", seenWords[2], 64'h2000_9666_6000_0000);

        $display("[TB] LOAD_WT len=2 with two stall cycles");
        seenWords.delete();
        applyStimulus(3'd1, 16'h0200, 8'd2, 1'b1, 8'b0000_1001, 0);
        @(negedge clk); #1;
        checkOutput("ldwt_done_lat", 64'(lastDoneCycle - acceptCycle), 64'd5);
        loadWtWords = 0;
        nopWords    = 0;
        foreach (seenWords[i]) begin
            if (seenWords[i][63:59] == 5'b00101) loadWtWords++;
            if (seenWords[i] == NOP_WORD)        nopWords++;
        end
        checkOutput("ldwt_data_words", 64'(loadWtWords), 64'd2);
        checkOutput("ldwt_stall_words", 64'(nopWords), 64'(STALLS_LOGGED));

        $display("[TB] RUN_MAC addr=0xFFFF len=2");
        seenWords.delete();
        applyStimulus(3'd2, 16'hFFFF, 8'd2, 1'b0, 8'h0, 0);
        checkOutput("mac_count", 64'(seenWords.size()), 64'd2);
        checkOutput("mac_w0", seenWords[0], 64'h0FFF_F800_0000_0000);
        checkOutput("mac_w1", seenWords[1], 64'h0800_0000_0000_0000);

        $display("[TB] STORE_OUT len=0");
        seenWords.delete();
        applyStimulus(3'd4, 16'h0050, 8'd0, 1'b0, 8'h0, 0);
        @(negedge clk); #1;
        checkOutput("len0_done_lat", 64'(lastDoneCycle - acceptCycle), 64'd1);
        checkOutput("len0_words", 64'(seenWords.size()), 64'd0);

        $display("[TB] reserved op 7");
        seenWords.delete();
        applyStimulus(3'd7, 16'h1111, 8'd5, 1'b0, 8'h0, 0);
        @(negedge clk); #1;
        checkOutput("rsvd_err_lat", 64'(lastErrCycle - acceptCycle), 64'd1);
        checkOutput("rsvd_done_lat", 64'(lastDoneCycle - acceptCycle), 64'd1);
        checkOutput("rsvd_words", 64'(seenWords.size()), 64'd0);

        $display("[TB] XMIT_OUT len=4 aborted by reset");
        @(posedge clk); #1;
        seenWords.delete();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd5;
        bus.cmd_addr  = 16'h0003;
        bus.cmd_len   = 8'd4;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        expQ.push_back(mkExp(64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
        expQ.push_back(mkExp(expWord(3'd5, 16'h0003, 16'h0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
        expQ.push_back(mkExp(expWord(3'd5, 16'h0004, 16'h0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk); #1;
        doneBefore = lastDoneCycle;
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("abort_instr", bus.instruction, 64'h0);
        checkOutput("abort_busy", 64'(bus.busy), 64'h0);
        checkOutput("abort_ready", 64'(bus.cmd_ready), 64'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 64'(lastDoneCycle), 64'(doneBefore));
        checkOutput("abort_words", 64'(seenWords.size()), 64'd2);
        checkOutput("abort_w0", seenWords[0], 64'h3000_1800_0000_0000);
        checkOutput("abort_w1", seenWords[1], 64'h3000_2000_0000_0000);

        $display("[TB] WAIT len=1 after abort");
        seenWords.delete();
        applyStimulus(3'd6, 16'h1234, 8'd1, 1'b0, 8'h0, 0);
        checkOutput("wait_count", 64'(seenWords.size()), 64'd1);
        checkOutput("wait_word", seenWords[0], NOP_WORD);

        $display("[TB] random commands");
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  rOp;
            logic [15:0] rAddr;
            logic [7:0]  rLen;
            rOp   = 3'($urandom_range(0, 7));
            rAddr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
            rLen  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 5));
            applyStimulus(rOp, rAddr, rLen, 1'b0, 8'h0, 30);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
